boot_copy_ctr: RTL
==================

// Module: boot_copy_ctr
// PURPOSE
//  Boot controller feeding the internal-memory SRAM write master port.
//  After reset it holds the CPU in reset and copies the whole boot ROM into the
//  top of SRAM (byte base BOOT_OFFSET = 2^SRAM_ADDR_W - 2^BOOTROM_ADDR_W).
//  It then releases the CPU with boot=1. A single-address CPU control register
//  lets software clear boot and request a timed CPU reset pulse.
// PARAMETERS
//  DATA_W          32  data width; byte strobe width is DATA_W/8
//  ADDR_W          32  SRAM write address width (byte address)
//  SRAM_ADDR_W     15  log2 SRAM size in bytes
//  BOOTROM_ADDR_W  12  log2 boot ROM size in bytes; ROM words N = 2^(BOOTROM_ADDR_W-2)
//  RST_PULSE       5   cycles cpu_reset is held after a software reset request (>=1)
// PORTS
//  clk         in   1                 clock
//  rst         in   1                 reset, asynchronous, active-low
//  boot        out  1                 1 = boot program active (address offset applied downstream)
//  cpu_reset   out  1                 CPU reset, active-high
//  cpu_valid   in   1                 control register access request
//  cpu_wdata   in   2                 [0]=new boot value, [1]=CPU reset request
//  cpu_wstrb   in   DATA_W/8          nonzero = write, zero = read
//  cpu_rdata   out  DATA_W            {zeros, cpu_reset, boot}
//  cpu_ready   out  1                 access acknowledge
//  rom_r_valid out  1                 ROM read enable
//  rom_r_addr  out  BOOTROM_ADDR_W-2  ROM word address
//  rom_r_rdata in   DATA_W            ROM data: valid 1 cycle after enable, held while enable is low
//  sram_valid  out  1                 SRAM write request
//  sram_addr   out  ADDR_W            SRAM byte address
//  sram_wdata  out  DATA_W            SRAM write data
//  sram_wstrb  out  DATA_W/8          SRAM write strobes
//  sram_ready  in   1                 SRAM write accepted when sram_valid & sram_ready
// BEHAVIOUR
//  Reset (rst=0) values: state=S_RD, cnt=0, boot=1, cpu_reset=1, cpu_ready=0,
//   cpu_rdata=0, rom_r_valid=0, sram_valid=0, sram_wstrb=0, rst_cnt=0.
//  FSM:
//   S_RD: rom_r_valid=1 and rom_r_addr=cnt for exactly 1 cycle -> S_WR.
//   S_WR: sram_valid=1, sram_wstrb=all 1s, sram_wdata=rom_r_rdata,
//    sram_addr=BOOT_OFFSET+4*cnt (zero-extended to ADDR_W).
//    Hold all request signals stable until sram_ready=1.
//    On accept: if cnt==N-1 -> S_REL, else cnt+1 and -> S_RD.
//    No wrap: cnt never exceeds N-1.
//   S_REL: all SRAM/ROM request signals 0; 1 cycle -> S_RUN; cpu_reset=0 from S_RUN entry.
//   S_RUN: terminal state; copy never restarts except via rst.
//  Copy timing with sram_ready tied 1: 2 cycles/word.
//   cpu_reset falls 2N+1 cycles after the first S_RD cycle.
//  CPU register:
//   cpu_ready pulses 1 cycle after any cpu_valid, in every state.
//   cpu_rdata is registered alongside cpu_ready.
//   Writes are honoured only in S_RUN; in other states they are acknowledged and ignored.
//   S_RUN write: boot<=cpu_wdata[0] next cycle.
//    If cpu_wdata[1]=1: cpu_reset<=1 and rst_cnt<=RST_PULSE-1; cpu_reset stays 1 for
//    exactly RST_PULSE cycles, then returns to 0. A new request during the pulse reloads rst_cnt.
//   Reads return the pre-update values of boot and cpu_reset.
//  Simultaneous CPU write and pulse expiry: the write wins (pulse restarts).
//  rst asserted mid-copy: immediate return to reset values; copy restarts from word 0.
// TESTING (BOOTROM_ADDR_W=4 -> N=4, SRAM_ADDR_W=8 -> BOOT_OFFSET=0xF0, RST_PULSE=5)
//  1 Release rst, ROM words {A0,A1,A2,A3}, sram_ready=1 -> writes A0@0xF0, A1@0xF4,
//    A2@0xF8, A3@0xFC with wstrb=0xF; cpu_reset falls 9 cycles after the first S_RD; boot=1.
//  2 sram_ready held 0 for 3 cycles on word 2 -> sram_valid, sram_addr=0xF8 and data stay
//    stable, no ROM read is issued, and cpu_reset release is delayed by exactly 3 cycles.
//  3 In S_RUN, write wdata=2'b00 -> ready 1 cycle later, boot=0, cpu_reset stays 0;
//    a following read returns 0x0.
//  4 In S_RUN, write wdata=2'b10 -> cpu_reset=1 for exactly 5 cycles, then 0; boot=0.
//    Repeating the request at pulse cycle 3 extends the pulse to 5 cycles from the new write.
//  5 Pull rst low after the 2nd word is written -> all outputs return to reset values;
//    after release the copy restarts at 0xF0.
//  6 cpu_valid write of 2'b00 during copy -> cpu_ready pulses, boot stays 1, copy unaffected.

Source files
------------

// File: rtl/boot_copy_ctr.sv
// Boot controller: copies the boot ROM into the top of SRAM while the CPU is held
// in reset, then releases the CPU and serves a one-address boot/reset control register.
module boot_copy_ctr #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int SRAM_ADDR_W    = 15,
  parameter int BOOTROM_ADDR_W = 12,
  parameter int RST_PULSE      = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      boot,
  output logic                      cpu_reset,
  input  logic                      cpu_valid,
  input  logic [1:0]                cpu_wdata,
  input  logic [DATA_W/8-1:0]       cpu_wstrb,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic                      rom_r_valid,
  output logic [BOOTROM_ADDR_W-3:0] rom_r_addr,
  input  logic [DATA_W-1:0]         rom_r_rdata,
  output logic                      sram_valid,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  output logic [DATA_W/8-1:0]       sram_wstrb,
  input  logic                      sram_ready,
  output logic [1:0]                state_dbg
);

  localparam int CNT_W = BOOTROM_ADDR_W - 2;
  localparam int RC_W  = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [CNT_W-1:0]  LAST_WORD   = '1;
  localparam logic [63:0]       BOOT_OFF_64 = (64'd1 << SRAM_ADDR_W) - (64'd1 << BOOTROM_ADDR_W);
  localparam logic [ADDR_W-1:0] BOOT_OFFSET = ADDR_W'(BOOT_OFF_64);
  localparam logic [RC_W-1:0]   RC_LOAD     = RC_W'(RST_PULSE - 1);

  typedef enum logic [1:0] {
    S_RD  = 2'd0,
    S_WR  = 2'd1,
    S_REL = 2'd2,
    S_RUN = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RC_W-1:0]  rst_cnt;
  logic             accept;
  logic             cpu_wr;
  logic             pulse_req;

  // Handshake: an SRAM write transfers on a cycle where sram_valid & sram_ready;
  // while sram_valid is high without ready, addr/data/strobes are held unchanged.
  always_comb begin
    state_nxt   = state;
    rom_r_valid = 1'b0;
    sram_valid  = 1'b0;
    sram_wstrb  = '0;
    sram_addr   = '0;
    sram_wdata  = '0;
    case (state)
      S_RD: begin
        // The state rests at S_RD during reset, so the read is masked by rst.
        rom_r_valid = rst;
        state_nxt   = S_WR;
      end
      S_WR: begin
        sram_valid = 1'b1;
        sram_wstrb = '1;
        sram_addr  = BOOT_OFFSET + ADDR_W'({cnt, 2'b00});
        sram_wdata = rom_r_rdata;
        if (sram_ready) state_nxt = (cnt == LAST_WORD) ? S_REL : S_RD;
      end
      S_REL:   state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  assign rom_r_addr = cnt;
  assign accept     = sram_valid & sram_ready;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && cnt != LAST_WORD) cnt <= cnt + 1'b1;
    end
  end

  assign cpu_wr    = cpu_valid && (|cpu_wstrb) && (state == S_RUN);
  assign pulse_req = cpu_wr && cpu_wdata[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      boot      <= 1'b1;
    end else begin
      cpu_ready <= cpu_valid;
      if (cpu_valid) cpu_rdata <= {{(DATA_W-2){1'b0}}, cpu_reset, boot};
      if (cpu_wr) boot <= cpu_wdata[0];
    end
  end

  // A new request reloads the counter even on the cycle the old pulse would expire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_reset <= 1'b1;
      rst_cnt   <= '0;
    end else if (state == S_REL) begin
      cpu_reset <= 1'b0;
    end else if (pulse_req) begin
      cpu_reset <= 1'b1;
      rst_cnt   <= RC_LOAD;
    end else if (state == S_RUN && cpu_reset) begin
      if (rst_cnt == '0) cpu_reset <= 1'b0;
      else               rst_cnt   <= rst_cnt - 1'b1;
    end
  end

endmodule
